// File: rtl/image_set_sequencer.sv
// image_set_sequencer
// Consumer side of the image-setting handshake register. It waits for the host
// to mark an image as set, launches one layer run and counts the output words.
// It then writes a done or timeout code back into the register and holds an
// interrupt until the host clears the register to 00.
module image_set_sequencer #(
    parameter int unsigned OUT_WORDS      = 1024,
    parameter int unsigned COUNT_W        = 11,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         setting_done_condition,
    input  logic               host_write_signal,
    input  logic               out_valid,
    output logic               layer_start,
    output logic [1:0]         write_data,
    output logic               write_signal,
    output logic               irq,
    output logic [COUNT_W-1:0] word_count,
    output logic               timeout_flag
);

    // Register encodings shared with the host
    localparam logic [1:0] SDC_IDLE     = 2'b00;
    localparam logic [1:0] SDC_START    = 2'b01;
    localparam logic [1:0] CODE_DONE    = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    localparam logic [COUNT_W-1:0] LP_OUT_WORDS = COUNT_W'(OUT_WORDS);
    localparam logic [TO_W-1:0]    LP_TIMEOUT   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        RUN        = 3'd2,
        WRITEBACK  = 3'd3,
        WAIT_CLEAR = 3'd4
    } state_t;

    state_t             r_state;
    logic [COUNT_W-1:0] r_word_count;
    logic [TO_W-1:0]    r_idle_cnt;
    logic [1:0]         r_code;
    logic               r_timeout_flag;

    state_t             w_next_state;
    logic [COUNT_W-1:0] w_word_count_nxt;
    logic [TO_W-1:0]    w_idle_cnt_nxt;
    logic [1:0]         w_code_nxt;
    logic               w_timeout_flag_nxt;

    logic [COUNT_W-1:0] w_word_inc;
    logic [TO_W-1:0]    w_idle_inc;

    // Saturating increments; the FSM leaves RUN before either can wrap
    assign w_word_inc = (r_word_count == LP_OUT_WORDS) ? r_word_count : r_word_count + 1'b1;
    assign w_idle_inc = (r_idle_cnt == {TO_W{1'b1}}) ? r_idle_cnt : r_idle_cnt + 1'b1;

    // State and run bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_word_count   <= '0;
            r_idle_cnt     <= '0;
            r_code         <= 2'b00;
            r_timeout_flag <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_word_count   <= w_word_count_nxt;
            r_idle_cnt     <= w_idle_cnt_nxt;
            r_code         <= w_code_nxt;
            r_timeout_flag <= w_timeout_flag_nxt;
        end
    end

    // Next-state decode; abort beats completion, completion beats timeout
    always_comb begin
        w_next_state       = r_state;
        w_word_count_nxt   = r_word_count;
        w_idle_cnt_nxt     = r_idle_cnt;
        w_code_nxt         = r_code;
        w_timeout_flag_nxt = r_timeout_flag;

        case (r_state)
            IDLE: begin
                if (setting_done_condition == SDC_START) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                // out_valid is not counted while the datapath is being started
                w_word_count_nxt   = '0;
                w_idle_cnt_nxt     = '0;
                w_timeout_flag_nxt = 1'b0;
                w_next_state       = RUN;
            end
            RUN: begin
                if (setting_done_condition == SDC_IDLE) begin
                    // Host withdrew the image: drop the run silently
                    w_next_state = IDLE;
                end else if (out_valid) begin
                    w_word_count_nxt = w_word_inc;
                    w_idle_cnt_nxt   = '0;
                    if (w_word_inc == LP_OUT_WORDS) begin
                        w_code_nxt   = CODE_DONE;
                        w_next_state = WRITEBACK;
                    end
                end else begin
                    w_idle_cnt_nxt = w_idle_inc;
                    if (w_idle_inc == LP_TIMEOUT) begin
                        w_code_nxt         = CODE_TIMEOUT;
                        w_timeout_flag_nxt = 1'b1;
                        w_next_state       = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                // Host owns the write port when it is writing; retry next cycle
                if (!host_write_signal) begin
                    w_next_state = WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                if (setting_done_condition == SDC_IDLE) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; only the write strobe sees the host
    always_comb begin
        layer_start  = (r_state == LAUNCH);
        irq          = (r_state == WAIT_CLEAR);
        write_data   = (r_state == WRITEBACK) ? r_code : 2'b00;
        write_signal = (r_state == WRITEBACK) && !host_write_signal;
        word_count   = r_word_count;
        timeout_flag = r_timeout_flag;
    end

endmodule

// File: doc/image_set_sequencer.md
# image_set_sequencer

Consumer side of the image-setting handshake register. It watches the 2-bit setting/done condition that the host writes, launches one layer computation when the host marks the image as set, and counts the layer's output words. On completion or timeout it writes a status code back into the same register through the register's write port. It then holds an interrupt until the host clears the register. It sits between the host-facing setting register and the one-layer CNN datapath.

## Interface

Parameters:
- OUT_WORDS, 1024: output words per layer run; reaching this count means the run is done.
- COUNT_W, 11: width of the word counter; must hold OUT_WORDS.
- TIMEOUT_CYCLES, 65535: consecutive RUN cycles without out_valid that count as a hung layer.
- TO_W, 16: width of the idle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- setting_done_condition, input, 2: current register value. 00 = idle, 01 = image set (start), 10 = layer done, 11 = layer error.
- host_write_signal, input, 1: host is writing the register this cycle. The host has priority on the register's single write port.
- out_valid, input, 1: one pulse per output word produced by the layer.
- layer_start, output, 1: one-cycle start pulse to the datapath.
- write_data, output, 2: status code written back to the register.
- write_signal, output, 1: write strobe to the register.
- irq, output, 1: level interrupt to the host.
- word_count, output, COUNT_W: output words counted in the current or last run.
- timeout_flag, output, 1: the last run ended by timeout.

## Operation

FSM states: IDLE, LAUNCH, RUN, WRITEBACK, WAIT_CLEAR.

- IDLE: if setting_done_condition == 01, go to LAUNCH. Any other value keeps the FSM in IDLE.
- LAUNCH (exactly 1 cycle):
  - layer_start = 1.
  - Clear word_count, the idle counter and timeout_flag.
  - Ignore out_valid.
  - Go to RUN.
- RUN:
  - On out_valid: word_count += 1 and the idle counter is cleared. Without out_valid, the idle counter += 1.
  - Done: if the increment makes word_count == OUT_WORDS, latch code 10 and go to WRITEBACK.
  - Timeout: else if the idle counter reaches TIMEOUT_CYCLES, latch code 11, set timeout_flag and go to WRITEBACK.
  - Completion wins over timeout in the same cycle.
  - Host abort: if setting_done_condition == 00 during RUN, go to IDLE with no writeback. Abort has the highest priority.
- WRITEBACK:
  - write_signal = !host_write_signal and write_data = latched code.
  - If host_write_signal is high, stay in WRITEBACK and retry next cycle. Otherwise go to WAIT_CLEAR.
- WAIT_CLEAR:
  - irq = 1.
  - Go to IDLE only when setting_done_condition == 00.
  - A value of 01 seen here is ignored; the host must clear to 00 before the next start.
- word_count saturates at OUT_WORDS. Extra out_valid pulses in any state other than RUN are ignored.
- word_count and timeout_flag hold their values after the run so the host can read them until the next LAUNCH.

## Timing

- Reset (rst low, asynchronous): the FSM goes to IDLE and every output is 0 (layer_start, write_data, write_signal, irq, word_count, timeout_flag), with both internal counters at 0.
- Reset asserted mid-run drops all outputs immediately. No writeback occurs.
- All outputs are decoded from registered state except write_signal, which is gated combinationally by host_write_signal.
- Start latency: start code 01 sampled at edge 0 gives layer_start high in cycle 1. RUN begins in cycle 2.
- Done latency (no host contention):
  - Final out_valid sampled at edge n gives write_signal high in cycle n+1.
  - The register holds 10 and irq is high from cycle n+2.
- Timeout: the idle counter reaches TIMEOUT_CYCLES after TIMEOUT_CYCLES consecutive RUN cycles without out_valid. write_signal rises the next cycle.
- irq falls the cycle after setting_done_condition == 00 is sampled in WAIT_CLEAR.
- Minimum turnaround from the clear to the next layer_start is 2 cycles.

## Test plan

Bench parameters: OUT_WORDS = 4, TIMEOUT_CYCLES = 8.

1. Normal run: write 01, then give 4 out_valid pulses spaced 2 cycles apart.
   - layer_start pulses exactly once.
   - write_signal pulses once with write_data = 10 and word_count = 4.
   - irq rises, then falls after the host writes 00.
2. Timeout: write 01, give 2 out_valid pulses, then none.
   - Writeback code 11 occurs exactly 8 cycles after the last pulse.
   - timeout_flag = 1 and word_count = 2.
3. Host contention: hold host_write_signal high for 3 cycles at the writeback point.
   - write_signal stays low for those 3 cycles, then pulses for one cycle with 10.
4. Host abort: write 00 after 2 out_valid pulses.
   - The FSM returns to IDLE with no write_signal and irq stays 0.
   - A new 01 restarts the run with word_count cleared.
5. Boundaries:
   - 4th out_valid in the same cycle the idle counter hits 8: code 10 wins.
   - Extra out_valid pulses after done: word_count stays 4.
   - 01 written during WAIT_CLEAR without a clear: ignored.
6. Reset: assert rst low in RUN and in WAIT_CLEAR.
   - All outputs are 0 immediately.
   - After rst is released, the FSM is in IDLE.
